// File: rtl/dtpmod_capture.sv
// Captures a byte from a two-digit multiplexed 7-segment PMOD bus: each digit
// pattern must hold steady before it is decoded and assembled into byte_out.
module dtpmod_capture #(
    parameter int STABLE_CYCLES = 4,
    parameter int TIMEOUT_BITS  = 12
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] pmod,
    output logic [7:0] byte_out,
    output logic       valid,
    output logic       code_err,
    output logic       blank,
    output logic       stalled
);

    typedef enum logic {IDLE, HAVE_HI} state_t;

    localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [3:0] STABLE_SAT  = 4'(STABLE_CYCLES);
    localparam logic [TIMEOUT_BITS-1:0] TMAX  = '1;
    localparam logic [TIMEOUT_BITS-1:0] TNEAR = {{(TIMEOUT_BITS-1){1'b1}}, 1'b0};
    localparam logic [TIMEOUT_BITS-1:0] TONE  = TIMEOUT_BITS'(1);

    logic [7:0] sync1, sync2, sprev;
    logic [3:0] stable_cnt;
    logic       same, accept;
    logic [TIMEOUT_BITS-1:0] tcount;
    logic       last_sel, sel_change, timeout;
    logic       code_ok, code_blank;
    logic [3:0] nib;
    state_t     state, next_state;
    logic [3:0] hi, hi_next;
    logic [7:0] byte_next;
    logic       valid_next, err_next, blank_next;

    // Accept fires exactly once per stable run, the cycle the run length hits STABLE_CYCLES.
    assign same       = (sync2 == sprev);
    assign accept     = same && (stable_cnt == STABLE_LAST);
    assign sel_change = accept && (sync2[7] != last_sel);
    assign timeout    = (tcount == TMAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1      <= 8'hFF;
            sync2      <= 8'hFF;
            sprev      <= 8'hFF;
            stable_cnt <= 4'd0;
        end else begin
            sync1 <= pmod;
            sync2 <= sync1;
            sprev <= sync2;
            if (!same)
                stable_cnt <= 4'd0;
            else if (stable_cnt != STABLE_SAT)
                stable_cnt <= stable_cnt + 4'd1;
        end
    end

    // Segment patterns are active low; 7F is a dark digit.
    always_comb begin
        code_ok    = 1'b1;
        code_blank = 1'b0;
        nib        = 4'h0;
        case (sync2[6:0])
            7'b0000010: nib = 4'h0;
            7'b0101111: nib = 4'h1;
            7'b1000001: nib = 4'h2;
            7'b0000101: nib = 4'h3;
            7'b0101100: nib = 4'h4;
            7'b0010100: nib = 4'h5;
            7'b0010000: nib = 4'h6;
            7'b0001111: nib = 4'h7;
            7'b0000000: nib = 4'h8;
            7'b0001100: nib = 4'h9;
            7'b0001000: nib = 4'hA;
            7'b0110000: nib = 4'hB;
            7'b1110001: nib = 4'hC;
            7'b0100001: nib = 4'hD;
            7'b1010000: nib = 4'hE;
            7'b1011000: nib = 4'hF;
            7'b1111111: begin
                code_ok    = 1'b0;
                code_blank = 1'b1;
            end
            default: code_ok = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tcount   <= '0;
            stalled  <= 1'b0;
            last_sel <= 1'b1;
        end else begin
            if (accept)
                last_sel <= sync2[7];
            if (sel_change) begin
                tcount  <= '0;
                stalled <= 1'b0;
            end else begin
                if (tcount != TMAX)
                    tcount <= tcount + TONE;
                if (tcount >= TNEAR)
                    stalled <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            hi       <= 4'h0;
            byte_out <= 8'h00;
            valid    <= 1'b0;
            code_err <= 1'b0;
            blank    <= 1'b0;
        end else begin
            state    <= next_state;
            hi       <= hi_next;
            byte_out <= byte_next;
            valid    <= valid_next;
            code_err <= err_next;
            blank    <= blank_next;
        end
    end

    // A stalled bus drops any half-captured frame until the select toggles again.
    always_comb begin
        next_state = state;
        hi_next    = hi;
        byte_next  = byte_out;
        valid_next = 1'b0;
        err_next   = 1'b0;
        blank_next = blank;
        if (accept) begin
            if (!sync2[7]) begin
                next_state = IDLE;
                if (code_ok) begin
                    hi_next    = nib;
                    blank_next = 1'b0;
                    next_state = HAVE_HI;
                end else if (code_blank) begin
                    blank_next = 1'b1;
                end else begin
                    err_next   = 1'b1;
                    blank_next = 1'b0;
                end
            end else if (state == HAVE_HI) begin
                next_state = IDLE;
                if (code_ok) begin
                    byte_next  = {hi, nib};
                    valid_next = 1'b1;
                end else if (!code_blank) begin
                    err_next = 1'b1;
                end
            end
        end
        if (timeout && !sel_change)
            next_state = IDLE;
    end

endmodule
